// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: instruction field positions, widths and decode-stage state encoding
package decode_stage_pkg;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W = 6;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int REG_W = 5;
  localparam int SHAMT_LSB = 6;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_W = 6;
  localparam int JT_LSB = 0;
  localparam int JT_W = 26;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;
endpackage

// File: rtl/decode_stage_sign_extend.sv
// sign_extend: replicate the immediate's top bit into the upper result bits
module sign_extend #(
  parameter int IN_WIDTH = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic [OUT_WIDTH-1:0] data_out
);
  assign data_out = {{(OUT_WIDTH-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with a one-entry skid buffer and accept counter
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_instr,
  input  logic [DATA_WIDTH-1:0]  in_pc,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_pc,
  output logic [OPCODE_W-1:0]    out_opcode,
  output logic [REG_W-1:0]       out_rs,
  output logic [REG_W-1:0]       out_rt,
  output logic [REG_W-1:0]       out_rd,
  output logic [SHAMT_W-1:0]     out_shamt,
  output logic [FUNCT_W-1:0]     out_funct,
  output logic [DATA_WIDTH-1:0]  out_imm_ext,
  output logic [JT_W-1:0]        out_jtarget,
  output logic [COUNT_WIDTH-1:0] decode_count
);
  state_t state, state_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_pc_q, skid_instr, skid_pc, w;
  logic accept, drain;

  assign accept = in_valid && in_ready && !flush;
  assign out_valid = state != EMPTY;
  assign drain = out_valid && out_ready;

  // next state: flush empties everything regardless of the handshakes
  always_comb begin
    state_d = state;
    unique case (state)
      EMPTY:   state_d = accept ? FULL : EMPTY;
      FULL:    state_d = (accept && !drain) ? SKID : (drain && !accept) ? EMPTY : FULL;
      SKID:    state_d = drain ? FULL : SKID;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // state, payload slots, ready flag and accept counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      out_instr_q <= '0;
      out_pc_q <= '0;
      skid_instr <= '0;
      skid_pc <= '0;
      decode_count <= '0;
    end else begin
      state <= state_d;
      in_ready <= state_d != SKID;
      decode_count <= decode_count + COUNT_WIDTH'(accept);
      if (flush) begin
        out_instr_q <= '0;
        out_pc_q <= '0;
        skid_instr <= '0;
        skid_pc <= '0;
      end else begin
        if (state == SKID && drain) begin
          out_instr_q <= skid_instr;
          out_pc_q <= skid_pc;
        end else if (accept && (state == EMPTY || drain)) begin
          out_instr_q <= in_instr;
          out_pc_q <= in_pc;
        end
        if (accept && state == FULL && !drain) begin
          skid_instr <= in_instr;
          skid_pc <= in_pc;
        end
      end
    end
  end

  assign w = out_valid ? out_instr_q : '0;
  assign out_pc = out_valid ? out_pc_q : '0;
  assign out_opcode = w[OPCODE_LSB +: OPCODE_W];
  assign out_rs = w[RS_LSB +: REG_W];
  assign out_rt = w[RT_LSB +: REG_W];
  assign out_rd = w[RD_LSB +: REG_W];
  assign out_shamt = w[SHAMT_LSB +: SHAMT_W];
  assign out_funct = w[FUNCT_LSB +: FUNCT_W];
  assign out_jtarget = w[JT_LSB +: JT_W];

  sign_extend #(.IN_WIDTH(IMM_WIDTH), .OUT_WIDTH(DATA_WIDTH)) u_sext (
    .data_in(w[IMM_WIDTH-1:0]),
    .data_out(out_imm_ext)
  );
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a queue model
module tb_decode_stage;
  logic clk, reset, flush, in_valid, in_ready, out_ready, out_valid;
  logic [31:0] in_instr, in_pc, out_pc, out_imm_ext;
  logic [5:0] out_opcode, out_funct;
  logic [4:0] out_rs, out_rt, out_rd, out_shamt;
  logic [25:0] out_jtarget;
  logic [15:0] decode_count;
  logic [139:0] obs;
  logic [31:0] iq[$], pq[$];
  logic [15:0] cnt_m;
  logic rdy_m;
  int tests = 0, fails = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct),
    .out_imm_ext(out_imm_ext), .out_jtarget(out_jtarget), .decode_count(decode_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
                out_imm_ext, out_jtarget, decode_count, in_ready};

  function automatic logic [139:0] expv();
    logic [31:0] w, p;
    w = iq.size() > 0 ? iq[0] : 32'h0;
    p = pq.size() > 0 ? pq[0] : 32'h0;
    return {iq.size() > 0, p, 6'(w >> 26), 5'(w >> 21), 5'(w >> 16), 5'(w >> 11), 5'(w >> 6),
            6'(w), 32'($signed(16'(w))), 26'(w), cnt_m, rdy_m};
  endfunction

  task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic ordy, input logic fl, input logic rs);
    logic acc;
    in_valid = v;
    in_instr = i;
    in_pc = p;
    out_ready = ordy;
    flush = fl;
    reset = rs;
    @(posedge clk);
    if (rs) begin
      iq.delete();
      pq.delete();
      cnt_m = 16'h0;
      rdy_m = 1'b0;
    end else if (fl) begin
      iq.delete();
      pq.delete();
      rdy_m = 1'b1;
    end else begin
      acc = v && rdy_m;
      if (iq.size() > 0 && ordy) begin
        void'(iq.pop_front());
        void'(pq.pop_front());
      end
      if (acc) begin
        iq.push_back(i);
        pq.push_back(p);
        cnt_m = cnt_m + 16'd1;
      end
      rdy_m = iq.size() < 2;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
    tests++;
    if (obs !== 140'h0) begin
      fails++;
      $display("FAIL reset_zero: got %h exp 0", obs);
    end
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b1);
    tests++;
    if (obs !== expv()) begin
      fails++;
      $display("FAIL reset_hold: got %h exp %h", obs, expv());
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 32'h2008FFFF, 32'h40, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, out_opcode, out_rs, out_rt, out_imm_ext, out_pc, decode_count} !==
        {1'b1, 6'h08, 5'd0, 5'd8, 32'hFFFFFFFF, 32'h40, 16'd1}) begin
      fails++;
      $display("FAIL addi_fields: got %b %h %h %h %h %h %h exp 1 08 00 08 ffffffff 00000040 0001",
               out_valid, out_opcode, out_rs, out_rt, out_imm_ext, out_pc, decode_count);
    end
    cycle(1'b1, 32'h8C437FFF, 32'h44, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_opcode, out_rs, out_rt, out_rd, out_imm_ext} !==
        {6'h23, 5'd2, 5'd3, 5'h0F, 32'h00007FFF}) begin
      fails++;
      $display("FAIL lw_fields: got %h %h %h %h %h exp 23 02 03 0f 00007fff",
               out_opcode, out_rs, out_rt, out_rd, out_imm_ext);
    end
    tests++;
    if (obs !== expv()) begin
      fails++;
      $display("FAIL basic_model: got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_skid();
    logic [31:0] pa, pb;
    pa = $urandom;
    pb = $urandom;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, $urandom, pa, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, pb, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, pa} || obs !== expv()) begin
      fails++;
      $display("FAIL skid_fill: got rdy %b v %b pc %h exp 0 1 %h", in_ready, out_valid, out_pc, pa);
    end
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({in_ready, out_pc} !== {1'b0, pa} || obs !== expv()) begin
      fails++;
      $display("FAIL skid_hold: got rdy %b pc %h exp 0 %h", in_ready, out_pc, pa);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({out_valid, out_pc, in_ready} !== {1'b1, pb, 1'b1} || obs !== expv()) begin
      fails++;
      $display("FAIL skid_drain_b: got v %b pc %h rdy %b exp 1 %h 1", out_valid, out_pc, in_ready, pb);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (out_valid !== 1'b0 || obs !== expv()) begin
      fails++;
      $display("FAIL skid_empty: got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    c0 = decode_count;
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({out_valid, in_ready, decode_count} !== {1'b0, 1'b1, c0} || obs !== expv()) begin
      fails++;
      $display("FAIL flush_skid: got v %b rdy %b cnt %h exp 0 1 %h", out_valid, in_ready, decode_count, c0);
    end
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
    tests++;
    if (obs !== expv() || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_full: got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(3) != 0, $urandom, $urandom, $urandom_range(2) != 0,
            $urandom_range(15) == 0, 1'b0);
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL random_%0d: got %h exp %h", n, obs, expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    tests++;
    if (obs !== 140'h0) begin
      fails++;
      $display("FAIL reset_mid: got %h exp 0", obs);
    end
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
    tests++;
    if (obs !== 140'h0) begin
      fails++;
      $display("FAIL reset_mid_hold: got %h exp 0", obs);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({in_ready, out_valid} !== 2'b10 || obs !== expv()) begin
      fails++;
      $display("FAIL reset_mid_release: got rdy %b v %b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    while (cnt_m != 16'hFFFF && n < 70000) begin
      cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      n++;
    end
    tests++;
    if (decode_count !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_preload: got %h exp ffff", decode_count);
    end
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    tests++;
    if (decode_count !== 16'h0000 || obs !== expv()) begin
      fails++;
      $display("FAIL wrap_zero: got %h exp 0000", decode_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
